div16_seq_ctrl: RTL and testbench



---
 rtl/div16_seq_ctrl_pkg.sv | 13 +
 rtl/adder_sub16bit.sv | 18 +
 rtl/div16_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_div16_seq_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/div16_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 16-bit divider controller.
// State encoding is private to the divider; the divide-by-zero quotient is visible to its users.
package div16_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] DIV_BY_ZERO_QUOT = 16'hFFFF;

endpackage

// File: rtl/adder_sub16bit.sv
// 16-bit adder/subtractor: op_i=0 adds, op_i=1 computes a_i - b_i; combinational.
// In subtract mode cout_o=1 means no borrow (a_i >= b_i); no flow control.
module adder_sub16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        op_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] b_eff;
    logic [16:0] full;

    assign b_eff           = op_i ? ~b_i : b_i;
    assign full            = {1'b0, a_i} + {1'b0, b_eff} + {16'd0, op_i};
    assign {cout_o, sum_o} = full;

endmodule

// File: rtl/div16_seq_ctrl.sv
// Unsigned 16/16 restoring divider, one quotient bit per clock through a shared subtractor.
// Latency: done 17 cycles after an accepted start (1 for divide-by-zero); start ignored while busy.
module div16_seq_ctrl
    import div16_seq_ctrl_pkg::*;
#(
    parameter int ITERS = 16,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    state_t            state_q, state_d;
    logic [15:0]       q_q, q_d;
    logic [14:0]       r_q, r_d;
    logic [15:0]       d_q, d_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       quot_q, quot_d;
    logic [15:0]       rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [15:0]       shift_w;
    logic [15:0]       diff_w;
    logic              ge_w;
    logic [15:0]       r_next_w;
    logic [15:0]       q_next_w;

    // The partial remainder never reaches 2^15 before a shift, so only 15 bits are
    // stored; the full 16-bit value of the final iteration goes straight to rem_q.
    assign shift_w  = {r_q, q_q[15]};
    assign r_next_w = ge_w ? diff_w : shift_w;
    assign q_next_w = {q_q[14:0], ge_w};

    adder_sub16bit u_trial_sub (
        .a_i    (shift_w),
        .b_i    (d_q),
        .op_i   (1'b1),
        .sum_o  (diff_w),
        .cout_o (ge_w)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (divisor != 16'd0) begin
                        state_d = ST_BUSY;
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        quot_d  = DIV_BY_ZERO_QUOT;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                q_d   = q_next_w;
                r_d   = r_next_w[14:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = q_next_w;
                    rem_d   = r_next_w;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_BUSY);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16_seq_ctrl.sv
// Scoreboard bench for div16_seq_ctrl: stimulus pushes expected results, a negedge monitor checks them.
module tb_div16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   last_done = 0;
    int   busy_run  = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    div16_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer division; edge counts follow the handshake timing.
    function automatic exp_t model(input logic [15:0] dvd, input logic [15:0] dvs, input int acc);
        exp_t e;
        if (dvs == 16'd0) begin
            e.q = 16'hFFFF; e.r = dvd; e.dbz = 1'b1; e.done_cyc = acc;
        end else begin
            e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0; e.done_cyc = acc + 16;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("busy_len", 32'(busy_run), e.dbz ? 32'd0 : 32'd16);
                end
                busy_run = 0;
            end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                check("done_timeout", 32'(cyc), 32'(sb[0].done_cyc));
                void'(sb.pop_front());
            end
        end
    end

    // Waits until the DUT can accept, scribbling on the operands meanwhile, then issues.
    task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs, input bit hold, output int acc);
        @(negedge clk);
        while (cyc < last_done) begin
            start    = 1'b0;
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            @(negedge clk);
        end
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        acc      = cyc + 1;
        sb.push_back(model(dvd, dvs, acc));
        last_done = sb[$].done_cyc;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int          acc;
        int          t;
        logic [15:0] dvd, dvs;

        rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        issue(16'd100, 16'd7, 1'b0, acc);
        issue(16'hFFFF, 16'd1, 1'b0, acc);
        issue(16'h8000, 16'hFFFF, 1'b0, acc);
        issue(16'd5, 16'd0, 1'b0, acc);

        // Start held high: the second division is picked up in the DONE cycle.
        issue(16'd1000, 16'd3, 1'b1, acc);
        repeat (5) @(negedge clk);
        dividend = 16'd9;
        divisor  = 16'd9;
        acc = last_done + 1;
        sb.push_back(model(16'd9, 16'd9, acc));
        last_done = sb[$].done_cyc;
        while (cyc < acc) @(negedge clk);
        start = 1'b0;

        // Reset mid-division discards the pending result.
        issue(16'd50000, 16'd7, 1'b0, acc);
        while (cyc < acc + 8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quot", 32'(quotient), 32'd0);
        check("midrst_rem", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        last_done = 0;
        @(negedge clk);
        check("rst_hold_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(16'd50, 16'd5, 1'b0, acc);

        for (int i = 0; i < 40; i++) begin
            dvd = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       dvs = 16'd0;
                1:       dvs = 16'd1;
                2:       dvs = 16'($urandom_range(2, 15));
                3:       dvs = (dvd == 16'hFFFF) ? dvd : dvd + 16'($urandom_range(1, 16'hFFFF - dvd));
                default: dvs = 16'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(dvd, dvs, 1'b0, acc);
        end

        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) check("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
